// File: rtl/cmd_parse.sv
// ASCII command parser: "L<hex><hex><CR>" from a UART byte stream, with inter-character timeout.
// Optional build macro CMD_PARSE_LOWER_EN also accepts 'l' as start and lowercase a-f as hex.
module cmd_parse #(
   parameter int TIMEOUT_CYC = 1_250_000
) (
   input  logic       clk_rx,
   input  logic       rst_clk_rx,
   input  logic [7:0] rx_data,
   input  logic       rx_data_rdy,
   output logic [7:0] cmd_data,
   output logic       cmd_valid,
   output logic       cmd_err,
   output logic       busy
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {IDLE, HEX_HI, HEX_LO, WAIT_CR} state_t;

   state_t           state, state_next;
   logic [3:0]       hi, hi_next;
   logic [3:0]       lo, lo_next;
   logic [7:0]       data_next;
   logic             valid_next, err_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [4:0]       dec;
   logic             timeout;

   function automatic logic is_start(input logic [7:0] b);
`ifdef CMD_PARSE_LOWER_EN
      return (b == 8'h4C) || (b == 8'h6C);
`else
      return (b == 8'h4C);
`endif
   endfunction

   // Returns {digit_ok, nibble}.
   function automatic logic [4:0] hex_decode(input logic [7:0] b);
      logic [4:0] r;
      r = 5'b0;
      if (b >= 8'h30 && b <= 8'h39)
         r = {1'b1, b[3:0]};
      else if (b >= 8'h41 && b <= 8'h46)
         r = {1'b1, b[3:0] + 4'd9};
`ifdef CMD_PARSE_LOWER_EN
      if (b >= 8'h61 && b <= 8'h66)
         r = {1'b1, b[3:0] + 4'd9};
`endif
      return r;
   endfunction

   always_comb begin
      state_next = state;
      hi_next    = hi;
      lo_next    = lo;
      data_next  = cmd_data;
      valid_next = 1'b0;
      err_next   = 1'b0;
      dec        = hex_decode(rx_data);
      // A byte arriving on the terminal count wins over the timeout.
      timeout    = (state != IDLE) && !rx_data_rdy && (cnt == CNT_TERM);

      if (rx_data_rdy) begin
         case (state)
            IDLE: begin
               if (is_start(rx_data))
                  state_next = HEX_HI;
            end
            HEX_HI: begin
               if (dec[4]) begin
                  hi_next    = dec[3:0];
                  state_next = HEX_LO;
               end else begin
                  err_next   = 1'b1;
                  state_next = IDLE;
               end
            end
            HEX_LO: begin
               if (dec[4]) begin
                  lo_next    = dec[3:0];
                  state_next = WAIT_CR;
               end else begin
                  err_next   = 1'b1;
                  state_next = IDLE;
               end
            end
            WAIT_CR: begin
               if (rx_data == 8'h0D) begin
                  data_next  = {hi, lo};
                  valid_next = 1'b1;
               end else begin
                  err_next   = 1'b1;
               end
               state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end else if (timeout) begin
         err_next   = 1'b1;
         state_next = IDLE;
      end

      if (rx_data_rdy || state == IDLE || timeout)
         cnt_next = '0;
      else if (cnt != CNT_TERM)
         cnt_next = cnt + CNT_W'(1);
      else
         cnt_next = cnt;
   end

   always_ff @(posedge clk_rx) begin
      if (rst_clk_rx) begin
         state     <= IDLE;
         hi        <= 4'h0;
         lo        <= 4'h0;
         cmd_data  <= 8'h00;
         cmd_valid <= 1'b0;
         cmd_err   <= 1'b0;
         busy      <= 1'b0;
         cnt       <= '0;
      end else begin
         state     <= state_next;
         hi        <= hi_next;
         lo        <= lo_next;
         cmd_data  <= data_next;
         cmd_valid <= valid_next;
         cmd_err   <= err_next;
         busy      <= (state_next != IDLE);
         cnt       <= cnt_next;
      end
   end

endmodule

// File: tb/tb_cmd_parse.sv
// Directed table-driven bench for cmd_parse with TIMEOUT_CYC=16, plus timeout/reset sequences.
module tb_cmd_parse;

   logic       clk_rx = 1'b0;
   logic       rst_clk_rx;
   logic [7:0] rx_data;
   logic       rx_data_rdy;
   logic [7:0] cmd_data;
   logic       cmd_valid;
   logic       cmd_err;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   cmd_parse #(.TIMEOUT_CYC(16)) dut (
      .clk_rx      (clk_rx),
      .rst_clk_rx  (rst_clk_rx),
      .rx_data     (rx_data),
      .rx_data_rdy (rx_data_rdy),
      .cmd_data    (cmd_data),
      .cmd_valid   (cmd_valid),
      .cmd_err     (cmd_err),
      .busy        (busy)
   );

   always #5 clk_rx = ~clk_rx;

   typedef struct {
      logic       rdy;
      logic [7:0] data;
      logic       v;
      logic       e;
      logic       b;
      logic [7:0] cmd;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic [7:0] d, input logic v,
                               input logic e, input logic b, input logic [7:0] c);
      vec_t t;
      t.rdy = r; t.data = d; t.v = v; t.e = e; t.b = b; t.cmd = c;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle of input, then check the registered outputs after the edge.
   task automatic step(input logic r, input logic [7:0] d, input logic v, input logic e,
                       input logic b, input logic [7:0] c, input string nm);
      rx_data_rdy = r;
      rx_data     = d;
      @(posedge clk_rx);
      #1;
      rx_data_rdy = 1'b0;
      rx_data     = 8'h00;
      chk({nm, ".valid"}, {7'b0, cmd_valid}, {7'b0, v});
      chk({nm, ".err"},   {7'b0, cmd_err},   {7'b0, e});
      chk({nm, ".busy"},  {7'b0, busy},      {7'b0, b});
      chk({nm, ".data"},  cmd_data,          c);
   endtask

   initial begin
      rst_clk_rx  = 1'b1;
      rx_data_rdy = 1'b1;
      rx_data     = 8'h4C;
      repeat (2) @(posedge clk_rx);
      #1;
      chk("rst.valid", {7'b0, cmd_valid}, 8'h00);
      chk("rst.err",   {7'b0, cmd_err},   8'h00);
      chk("rst.busy",  {7'b0, busy},      8'h00);
      chk("rst.data",  cmd_data,          8'h00);
      rst_clk_rx = 1'b0;
      step(0, 8'h00, 0, 0, 0, 8'h00, "post_rst_idle");

      tbl.push_back(mk(1, 8'h4C, 0, 0, 1, 8'h00));
      tbl.push_back(mk(1, 8'h41, 0, 0, 1, 8'h00));
      tbl.push_back(mk(1, 8'h35, 0, 0, 1, 8'h00));
      tbl.push_back(mk(1, 8'h0D, 1, 0, 0, 8'hA5));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 8'hA5));
      tbl.push_back(mk(1, 8'h4C, 0, 0, 1, 8'hA5));
      tbl.push_back(mk(1, 8'h47, 0, 1, 0, 8'hA5));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 8'hA5));
      tbl.push_back(mk(1, 8'h78, 0, 0, 0, 8'hA5));
      tbl.push_back(mk(1, 8'h4C, 0, 0, 1, 8'hA5));
      tbl.push_back(mk(1, 8'h33, 0, 0, 1, 8'hA5));
      tbl.push_back(mk(1, 8'h43, 0, 0, 1, 8'hA5));
      tbl.push_back(mk(1, 8'h0D, 1, 0, 0, 8'h3C));
      tbl.push_back(mk(1, 8'h4C, 0, 0, 1, 8'h3C));
      tbl.push_back(mk(1, 8'h4C, 0, 1, 0, 8'h3C));
      tbl.push_back(mk(1, 8'h4C, 0, 0, 1, 8'h3C));
      tbl.push_back(mk(1, 8'h31, 0, 0, 1, 8'h3C));
      tbl.push_back(mk(1, 8'h32, 0, 0, 1, 8'h3C));
      tbl.push_back(mk(1, 8'h5A, 0, 1, 0, 8'h3C));
      tbl.push_back(mk(1, 8'h4C, 0, 0, 1, 8'h3C));
      tbl.push_back(mk(1, 8'h31, 0, 0, 1, 8'h3C));
      tbl.push_back(mk(1, 8'h67, 0, 1, 0, 8'h3C));
      tbl.push_back(mk(1, 8'h4C, 0, 0, 1, 8'h3C));
      tbl.push_back(mk(1, 8'h40, 0, 1, 0, 8'h3C));
      tbl.push_back(mk(1, 8'h4C, 0, 0, 1, 8'h3C));
      tbl.push_back(mk(1, 8'h46, 0, 0, 1, 8'h3C));
      tbl.push_back(mk(1, 8'h30, 0, 0, 1, 8'h3C));
      tbl.push_back(mk(1, 8'h0D, 1, 0, 0, 8'hF0));
      tbl.push_back(mk(1, 8'h0D, 0, 0, 0, 8'hF0));
      tbl.push_back(mk(1, 8'h4C, 0, 0, 1, 8'hF0));
      tbl.push_back(mk(1, 8'h39, 0, 0, 1, 8'hF0));
      tbl.push_back(mk(1, 8'h0D, 0, 1, 0, 8'hF0));
      tbl.push_back(mk(1, 8'h4C, 0, 0, 1, 8'hF0));
      tbl.push_back(mk(1, 8'h30, 0, 0, 1, 8'hF0));
      tbl.push_back(mk(1, 8'h39, 0, 0, 1, 8'hF0));
      tbl.push_back(mk(1, 8'h0D, 1, 0, 0, 8'h09));

      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i].rdy, tbl[i].data, tbl[i].v, tbl[i].e, tbl[i].b, tbl[i].cmd,
              $sformatf("vec%0d", i));

      // Timeout: error registered 16 clocks after the 'L' is sampled.
      step(1, 8'h4C, 0, 0, 1, 8'h09, "to_start");
      for (int k = 1; k <= 16; k++)
         step(0, 8'h00, 0, (k == 16), (k < 16), 8'h09, $sformatf("to_wait%0d", k));
      step(0, 8'h00, 0, 0, 0, 8'h09, "to_after");

      // A byte on the terminal-count cycle suppresses the timeout.
      step(1, 8'h4C, 0, 0, 1, 8'h09, "term_start");
      for (int k = 1; k <= 15; k++)
         step(0, 8'h00, 0, 0, 1, 8'h09, $sformatf("term_wait%0d", k));
      step(1, 8'h37, 0, 0, 1, 8'h09, "term_byte");
      step(1, 8'h45, 0, 0, 1, 8'h09, "term_lo");
      step(1, 8'h0D, 1, 0, 0, 8'h7E, "term_cr");

`ifdef CMD_PARSE_LOWER_EN
      step(1, 8'h6C, 0, 0, 1, 8'h7E, "lower_l");
      step(1, 8'h66, 0, 0, 1, 8'h7E, "lower_f1");
      step(1, 8'h66, 0, 0, 1, 8'h7E, "lower_f2");
      step(1, 8'h0D, 1, 0, 0, 8'hFF, "lower_cr");
`else
      step(1, 8'h6C, 0, 0, 0, 8'h7E, "lower_l");
      step(1, 8'h66, 0, 0, 0, 8'h7E, "lower_f1");
      step(1, 8'h66, 0, 0, 0, 8'h7E, "lower_f2");
      step(1, 8'h0D, 0, 0, 0, 8'h7E, "lower_cr");
`endif

      // Reset mid-command with a coincident 'L' strobe that must be ignored.
      step(1, 8'h4C, 0, 0, 1, cmd_data, "mid_l");
      step(1, 8'h31, 0, 0, 1, cmd_data, "mid_1");
      rst_clk_rx = 1'b1;
      step(1, 8'h4C, 0, 0, 0, 8'h00, "mid_rst");
      rst_clk_rx = 1'b0;
      step(1, 8'h32, 0, 0, 0, 8'h00, "mid_2");
      step(1, 8'h0D, 0, 0, 0, 8'h00, "mid_cr");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cmd_parse.md
CMD_PARSE -- requirements
Module: cmd_parse

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1_250_000, inter-character timeout in clk_rx cycles (10 ms at 125 MHz); legal range 2 .. 2^24-1.
REQ-002 clk_rx  input  1  sole clock; all logic rising-edge.
REQ-003 rst_clk_rx  input  1  reset; one clock, synchronous, active-high reset.
REQ-004 rx_data  input  8  received byte from the UART receiver; valid only when rx_data_rdy=1.
REQ-005 rx_data_rdy  input  1  one-cycle strobe marking a new byte; no back-pressure, every strobe consumed.
REQ-006 cmd_data  output  8  last successfully parsed command value.
REQ-007 cmd_valid  output  1  one-cycle pulse, cmd_data updated this cycle.
REQ-008 cmd_err  output  1  one-cycle pulse, command aborted (bad byte or timeout).
REQ-009 busy  output  1  high while a command is partially received (state != IDLE).

Function
REQ-010 Command format SHALL be 'L' (0x4C), hex digit HI, hex digit LO, CR (0x0D); value = {HI,LO}.
REQ-011 States SHALL be IDLE, HEX_HI, HEX_LO, WAIT_CR; all outputs registered.
REQ-012 IDLE: 'L' -> HEX_HI; any other byte ignored silently, no cmd_err.
REQ-013 HEX_HI: hex digit -> nibble stored, HEX_LO; non-hex byte (including 'L') -> cmd_err, IDLE.
REQ-014 HEX_LO: hex digit -> nibble stored, WAIT_CR; non-hex -> cmd_err, IDLE.
REQ-015 WAIT_CR: 0x0D -> cmd_data={HI,LO}, cmd_valid, IDLE; any other byte -> cmd_err, IDLE, cmd_data unchanged.
REQ-016 Hex digits SHALL be 0x30-0x39 and 0x41-0x46 only (uppercase), unless REQ-027 applies.
REQ-017 cmd_valid/cmd_err SHALL assert exactly one cycle after the rx_data_rdy cycle of the deciding byte, for exactly one cycle; never both in one cycle.
REQ-018 cmd_data SHALL change only with cmd_valid and hold otherwise.
REQ-019 Timeout counter SHALL clear on every rx_data_rdy and while IDLE, else increment by 1 per cycle.
REQ-020 Counter reaching TIMEOUT_CYC-1 outside IDLE without rx_data_rdy -> cmd_err next cycle, IDLE, counter cleared.
REQ-021 rx_data_rdy in the same cycle as terminal count: byte processed normally, timeout suppressed.
REQ-022 Counter SHALL saturate, never wrap; width ceil(log2(TIMEOUT_CYC)).
REQ-023 busy SHALL be high from the cycle after 'L' is accepted until the cycle after the deciding byte or timeout.
REQ-024 rx_data_rdy on consecutive cycles SHALL each be processed (one byte per cycle throughput).

Reset
REQ-025 During rst_clk_rx: state IDLE, cmd_data=0x00, cmd_valid=0, cmd_err=0, busy=0, counter=0, stored nibbles=0.
REQ-026 Reset mid-command SHALL discard the partial command with no cmd_err; rx_data_rdy coincident with reset ignored.

Configuration
REQ-027 Macro CMD_PARSE_LOWER_EN defined: 'l' (0x6C) also starts a command and 0x61-0x66 accepted as hex a-f; undefined: those bytes treated as ordinary non-'L'/non-hex bytes per REQ-012..014.

Verification
REQ-028 Bytes 'L','A','5',0x0D -> cmd_valid one cycle after CR strobe, cmd_data=0xA5, cmd_err never high.
REQ-029 'L','G' -> cmd_err one cycle after 'G', busy low next, cmd_data keeps prior 0xA5.
REQ-030 TIMEOUT_CYC=16, 'L' then no bytes -> cmd_err exactly 16 cycles after 'L' strobe; byte landing on terminal cycle -> no cmd_err.
REQ-031 'x','L','3','C',0x0D on back-to-back cycles -> 'x' ignored, cmd_valid with cmd_data=0x3C.
REQ-032 'L','1', reset 1 cycle, then '2',0x0D -> no cmd_valid, no cmd_err, cmd_data=0x00.
REQ-033 'l','f','f',0x0D -> with CMD_PARSE_LOWER_EN cmd_data=0xFF valid; without it, no response (all ignored in IDLE).
